// File: rtl/reg_access_sequencer.sv
// Byte-level transaction sequencer between the I2C slave byte engine and the
// register bank: pointer load/increment, write strobes and read prefetch.
module reg_access_sequencer #(
  parameter int AddressWidth = 8,
  parameter int DataWidth    = 8,
  parameter int RegCount     = 16
) (
  input  logic                    CLK,
  input  logic                    _RST,
  input  logic                    BusStart,
  input  logic                    RWn,
  input  logic                    BusStop,
  input  logic                    RxValid,
  input  logic [DataWidth-1:0]    RxData,
  input  logic                    TxReq,
  input  logic [AddressWidth-1:0] AddressBus,
  input  logic [DataWidth-1:0]    RegRdData,
  output logic                    PtrLoad,
  output logic [AddressWidth-1:0] PtrLoadValue,
  output logic                    PtrInc,
  output logic                    RegWrEn,
  output logic [AddressWidth-1:0] RegWrAddr,
  output logic [DataWidth-1:0]    RegWrData,
  output logic [AddressWidth-1:0] RegRdAddr,
  output logic [DataWidth-1:0]    TxData,
  output logic                    TxValid,
  output logic                    TxUnderrun,
  output logic                    Busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, WRITE, RD_FETCH, RD_WAIT, RD_READY
  } state_t;

  // One extra bit so RegCount == 2^AddressWidth still compares correctly.
  localparam logic [AddressWidth:0] REG_LIMIT = (AddressWidth+1)'(RegCount);

  function automatic logic in_range(input logic [AddressWidth-1:0] a);
    return {1'b0, a} < REG_LIMIT;
  endfunction

  state_t                  state, state_n;
  logic                    ptr_load_n, ptr_inc_n, reg_wr_en_n;
  logic                    tx_valid_n, tx_underrun_n;
  logic [AddressWidth-1:0] ptr_load_value_n, reg_wr_addr_n, reg_rd_addr_n;
  logic [DataWidth-1:0]    reg_wr_data_n, tx_data_n;
  logic                    rd_state;

  assign rd_state = (state == RD_FETCH) || (state == RD_WAIT) || (state == RD_READY);

  always_comb begin
    state_n          = state;
    ptr_load_n       = 1'b0;
    ptr_load_value_n = PtrLoadValue;
    ptr_inc_n        = 1'b0;
    reg_wr_en_n      = 1'b0;
    reg_wr_addr_n    = RegWrAddr;
    reg_wr_data_n    = RegWrData;
    reg_rd_addr_n    = RegRdAddr;
    tx_data_n        = TxData;
    tx_valid_n       = TxValid;
    tx_underrun_n    = 1'b0;

    if (BusStop) begin
      state_n    = IDLE;
      tx_valid_n = 1'b0;
    end else if (BusStart) begin
      state_n    = RWn ? RD_FETCH : ADDR;
      tx_valid_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (RxValid) begin
          ptr_load_n       = 1'b1;
          ptr_load_value_n = AddressWidth'(RxData);
          state_n          = WRITE;
        end
        WRITE: if (RxValid) begin
          reg_wr_addr_n = AddressBus;
          reg_wr_data_n = RxData;
          reg_wr_en_n   = in_range(AddressBus);
          ptr_inc_n     = 1'b1;
        end
        RD_FETCH: begin
          reg_rd_addr_n = AddressBus;
          state_n       = RD_WAIT;
        end
        RD_WAIT: begin
          tx_data_n  = in_range(RegRdAddr) ? RegRdData : '0;
          tx_valid_n = 1'b1;
          ptr_inc_n  = 1'b1;
          state_n    = RD_READY;
        end
        RD_READY: if (TxReq && TxValid) begin
          tx_valid_n = 1'b0;
          state_n    = RD_FETCH;
        end
        default: ;
      endcase
      // Underrun is only meaningful while a read is in progress.
      if (TxReq && !TxValid && rd_state) tx_underrun_n = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state        <= IDLE;
      PtrLoad      <= 1'b0;
      PtrLoadValue <= '0;
      PtrInc       <= 1'b0;
      RegWrEn      <= 1'b0;
      RegWrAddr    <= '0;
      RegWrData    <= '0;
      RegRdAddr    <= '0;
      TxData       <= '0;
      TxValid      <= 1'b0;
      TxUnderrun   <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      state        <= state_n;
      PtrLoad      <= ptr_load_n;
      PtrLoadValue <= ptr_load_value_n;
      PtrInc       <= ptr_inc_n;
      RegWrEn      <= reg_wr_en_n;
      RegWrAddr    <= reg_wr_addr_n;
      RegWrData    <= reg_wr_data_n;
      RegRdAddr    <= reg_rd_addr_n;
      TxData       <= tx_data_n;
      TxValid      <= tx_valid_n;
      TxUnderrun   <= tx_underrun_n;
      Busy         <= (state_n != IDLE);
    end
  end

endmodule
